// File: rtl/hdmi_stream_gen_pkg.sv
// Shared types and constants for the hdmi_stream_gen video source:
// FSM state encoding, 24-bit RGB pixel type and the colour-bar palette.
package hdmi_stream_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  typedef logic [23:0] rgb_t;

  localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
  localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
  localparam rgb_t BAR_CYAN    = 24'h00FFFF;
  localparam rgb_t BAR_GREEN   = 24'h00FF00;
  localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
  localparam rgb_t BAR_RED     = 24'hFF0000;
  localparam rgb_t BAR_BLUE    = 24'h0000FF;
  localparam rgb_t BAR_BLACK   = 24'h000000;

  // Colour of vertical bar idx, left (0) to right (7).
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_stream_gen_counter.sv
// Horizontal/vertical raster counters and region decode for hdmi_stream_gen.
// Line order is ACT, FP, SYNC, BP both horizontally and vertically.
// Counters are held at 0 while run is low.
module hdmi_stream_gen_counter #(
  parameter int H_ACT  = 1280,
  parameter int H_FP   = 110,
  parameter int H_SYNC = 40,
  parameter int H_BP   = 220,
  parameter int V_ACT  = 720,
  parameter int V_FP   = 5,
  parameter int V_SYNC = 5,
  parameter int V_BP   = 20,
  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP,
  localparam int HCW     = $clog2(H_TOTAL),
  localparam int VCW     = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  output logic [HCW-1:0] h_cnt,
  output logic [VCW-1:0] v_cnt,
  output logic           act_region,
  output logic           in_hsync,
  output logic           in_vsync,
  output logic           frame_end
);

  logic [HCW-1:0] h_cnt_q, h_cnt_d;
  logic [VCW-1:0] v_cnt_q, v_cnt_d;
  logic           line_end;

  // Next-count and region decode from the current raster position.
  always_comb begin
    line_end   = (int'(h_cnt_q) == H_TOTAL - 1);
    frame_end  = line_end && (int'(v_cnt_q) == V_TOTAL - 1);
    act_region = (int'(h_cnt_q) < H_ACT) && (int'(v_cnt_q) < V_ACT);
    in_hsync   = (int'(h_cnt_q) >= H_ACT + H_FP) && (int'(h_cnt_q) < H_ACT + H_FP + H_SYNC);
    in_vsync   = (int'(v_cnt_q) >= V_ACT + V_FP) && (int'(v_cnt_q) < V_ACT + V_FP + V_SYNC);
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    if (!run) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (line_end) begin
      h_cnt_d = '0;
      v_cnt_d = frame_end ? '0 : v_cnt_q + 1'b1;
    end else begin
      h_cnt_d = h_cnt_q + 1'b1;
    end
  end

  // Raster position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt = h_cnt_q;
  assign v_cnt = v_cnt_q;

endmodule

// File: rtl/hdmi_stream_gen.sv
// hdmi_stream_gen: head of the packed video chain. Generates raster timing,
// pulls RGB pixels from an upstream valid/ready stream during the active area
// and emits o_pack = {clk, hsync, vsync, de, rgb, x, y} one cycle after the
// raster position it describes.
// Optional feature: define HDMI_TPG_EN to build the colour-bar test pattern
// selected by pattern_sel; without it pattern_sel is ignored.
module hdmi_stream_gen
  import hdmi_stream_gen_pkg::*;
#(
  parameter int H_ACT  = 1280,
  parameter int V_ACT  = 720,
  parameter int H_FP   = 110,
  parameter int H_SYNC = 40,
  parameter int H_BP   = 220,
  parameter int V_FP   = 5,
  parameter int V_SYNC = 5,
  parameter int V_BP   = 20,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1,
  localparam int XW     = $clog2(H_ACT),
  localparam int YW     = $clog2(V_ACT),
  localparam int PACK_W = 3*8 + 4 + XW + YW,
  localparam int HCW    = $clog2(H_ACT + H_FP + H_SYNC + H_BP),
  localparam int VCW    = $clog2(V_ACT + V_FP + V_SYNC + V_BP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              pix_valid,
  input  logic [23:0]       pix_data,
  output logic              pix_ready,
  input  logic              pattern_sel,
  output logic              frame_start,
  output logic [15:0]       underflow_cnt,
  output logic [PACK_W-1:0] o_pack
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e         state_q;
  logic           running;
  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic           act_region, in_hsync, in_vsync, frame_end;
  logic           de_cur, tpg_cur;
  rgb_t           bar_rgb;

  assign running = (state_q != ST_IDLE);

  hdmi_stream_gen_counter #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .run       (running),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .act_region(act_region),
    .in_hsync  (in_hsync),
    .in_vsync  (in_vsync),
    .frame_end (frame_end)
  );

  // Run control: en only decides whether the next frame starts; a started
  // frame always runs to its end so downstream never sees a truncated frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (en) state_q <= ST_RUN;
        ST_RUN: begin
          if (frame_end)  state_q <= en ? ST_RUN : ST_IDLE;
          else if (!en)   state_q <= ST_STOP;
        end
        ST_STOP: begin
          if (frame_end)  state_q <= en ? ST_RUN : ST_IDLE;
          else if (en)    state_q <= ST_RUN;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef HDMI_TPG_EN
  logic tpg_q, tpg_d;

  // Pattern selection is latched only when a frame begins so a frame is never mixed.
  always_comb begin
    tpg_d = tpg_q;
    if ((state_q == ST_IDLE && en) || (running && frame_end)) tpg_d = pattern_sel;
  end

  // Per-frame pattern select register.
  always_ff @(posedge clk) begin
    if (rst) tpg_q <= 1'b0;
    else     tpg_q <= tpg_d;
  end

  assign tpg_cur = running & tpg_q;
  assign bar_rgb = bar_colour(3'((int'(h_cnt) * 8) / H_ACT));
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  assign tpg_cur = 1'b0;
  assign bar_rgb = '0;
`endif

  assign de_cur    = running & act_region;
  assign pix_ready = de_cur & ~tpg_cur & ~rst;

  logic           hs_q, hs_d, vs_q, vs_d, de_q, fs_q, fs_d;
  rgb_t           rgb_q, rgb_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [15:0]    uf_q, uf_d;

  // Output-stage values for the current raster position; missing pixels become black.
  always_comb begin
    hs_d = (running & in_hsync) ? HS_POL : ~HS_POL;
    vs_d = (running & in_vsync) ? VS_POL : ~VS_POL;
    rgb_d = '0;
    if (de_cur) rgb_d = tpg_cur ? bar_rgb : (pix_valid ? pix_data : '0);
    x_d  = de_cur ? h_cnt[XW-1:0] : '0;
    y_d  = de_cur ? v_cnt[YW-1:0] : '0;
    fs_d = de_cur & (h_cnt == '0) & (v_cnt == '0);
    uf_d = (de_cur & ~tpg_cur & ~pix_valid) ? sat_inc(uf_q) : uf_q;
  end

  // Stage p0 -> output register: every o_pack field lags the raster by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      de_q  <= 1'b0;
      rgb_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      fs_q  <= 1'b0;
      uf_q  <= '0;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_cur;
      rgb_q <= rgb_d;
      x_q   <= x_d;
      y_q   <= y_d;
      fs_q  <= fs_d;
      uf_q  <= uf_d;
    end
  end

  assign frame_start   = fs_q;
  assign underflow_cnt = uf_q;
  assign o_pack        = {clk, hs_q, vs_q, de_q, rgb_q, x_q, y_q};

endmodule
